// File: rtl/proc_test_monitor.sv
// -----------------------------------------------------------------------------
// proc_test_monitor
//
// On-chip pass/fail checker that sits beside the single-cycle processor. It
// holds a small table of checkpoints, each a PC threshold plus the writeback
// value expected when the PC first reaches that threshold. During a run the
// checkpoints are evaluated strictly in order, one per cycle at most. Passes
// are counted and failures are flagged. A cycle watchdog ends a run that never
// reaches its last checkpoint.
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   resetl        synchronous active-low reset (clears results and table)
//   cfg_we        table write strobe, honoured only while idle
//   cfg_idx       table entry to write (indices >= NUM_TESTS are dropped)
//   cfg_pc        PC threshold for the entry being written
//   cfg_expected  expected writeback value for the entry being written
//   start         begin a run (honoured while idle, done or timed out)
//   currentpc     processor PC
//   memtoregout   processor writeback value
//   busy          run in progress
//   done          run finished (normally or by watchdog)
//   timeout       run ended by the watchdog
//   all_passed    run finished normally and every checkpoint passed
//   pass_count    checkpoints passed in this run
//   fail_mask     bit i set when checkpoint i failed or was never reached
//   cur_test      index of the checkpoint currently awaited
// -----------------------------------------------------------------------------
module proc_test_monitor #(
    parameter int NUM_TESTS  = 2,
    parameter int IDX_W      = 4,
    parameter int DATA_W     = 64,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 255
) (
    input  logic                 CLK,
    input  logic                 resetl,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [DATA_W-1:0]    cfg_pc,
    input  logic [DATA_W-1:0]    cfg_expected,
    input  logic                 start,
    input  logic [DATA_W-1:0]    currentpc,
    input  logic [DATA_W-1:0]    memtoregout,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 all_passed,
    output logic [IDX_W:0]       pass_count,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [IDX_W-1:0]     cur_test
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(NUM_TESTS - 1);
    localparam logic [IDX_W:0]    NUM_TESTS_CNT = (IDX_W + 1)'(NUM_TESTS);
    localparam logic [WDOG_W-1:0] WDOG_LAST     = WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX      = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_reg;
    state_t                state_next;
    logic [IDX_W:0]        pass_count_reg;
    logic [IDX_W:0]        pass_count_next;
    logic [NUM_TESTS-1:0]  fail_mask_reg;
    logic [NUM_TESTS-1:0]  fail_mask_next;
    logic [IDX_W-1:0]      cur_test_reg;
    logic [IDX_W-1:0]      cur_test_next;
    logic [WDOG_W-1:0]     wdog_reg;
    logic [WDOG_W-1:0]     wdog_next;

    // Checkpoint table. It is kept in flops rather than block RAM because
    // reset has to clear every entry in a single cycle.
    logic [DATA_W-1:0]     tab_pc_reg  [NUM_TESTS];
    logic [DATA_W-1:0]     tab_exp_reg [NUM_TESTS];

    // ------------------------------------------------------------------
    // Decode of the awaited checkpoint
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]     sel_pc;
    logic [DATA_W-1:0]     sel_exp;
    logic                  hit;
    logic                  match;
    logic                  last_test;
    logic                  wdog_expire;
    logic                  run_start;
    logic                  table_we;
    logic [NUM_TESTS-1:0]  cur_onehot;
    logic [NUM_TESTS-1:0]  tail_mask;

    // The read mux walks the real entries only. An out-of-range cur_test
    // cannot occur, but this way it would read zero rather than garbage.
    always_comb begin
        sel_pc  = '0;
        sel_exp = '0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            if (cur_test_reg == IDX_W'(i)) begin
                sel_pc  = tab_pc_reg[i];
                sel_exp = tab_exp_reg[i];
            end
        end
    end

    assign hit         = (currentpc >= sel_pc);
    assign match       = (memtoregout == sel_exp);
    assign last_test   = (cur_test_reg == LAST_IDX);
    assign wdog_expire = (wdog_reg == WDOG_LAST);
    assign run_start   = start && (state_reg != S_RUN);
    assign table_we    = cfg_we && (state_reg == S_IDLE);

    // cur_onehot marks the awaited checkpoint. tail_mask marks every
    // checkpoint after it, which are the ones a watchdog expiry leaves
    // unevaluated.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TESTS; gi++) begin : g_mask
            assign cur_onehot[gi] = (cur_test_reg == IDX_W'(gi));
            assign tail_mask[gi]  = (IDX_W'(gi) > cur_test_reg);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Checkpoint table writes
    // ------------------------------------------------------------------
    // The match on cfg_idx is done only against existing entries, so any
    // cfg_idx >= NUM_TESTS selects nothing and the write is dropped.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            for (int i = 0; i < NUM_TESTS; i++) begin
                tab_pc_reg[i]  <= '0;
                tab_exp_reg[i] <= '0;
            end
        end else if (table_we) begin
            for (int i = 0; i < NUM_TESTS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    tab_pc_reg[i]  <= cfg_pc;
                    tab_exp_reg[i] <= cfg_expected;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // A final hit takes priority over watchdog expiry on the same edge.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_RUN: begin
                if (hit && last_test) begin
                    state_next = S_DONE;
                end else if (wdog_expire) begin
                    state_next = S_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Run datapath: pass counter, fail mask, checkpoint index, watchdog
    // ------------------------------------------------------------------
    always_comb begin
        pass_count_next = pass_count_reg;
        fail_mask_next  = fail_mask_reg;
        cur_test_next   = cur_test_reg;
        wdog_next       = wdog_reg;

        if (run_start) begin
            pass_count_next = '0;
            fail_mask_next  = '0;
            cur_test_next   = '0;
            wdog_next       = '0;
        end else if (state_reg == S_RUN) begin
            if (wdog_reg != WDOG_MAX) begin
                wdog_next = wdog_reg + WDOG_W'(1);
            end

            // At most one checkpoint per cycle. A later threshold that is
            // already satisfied is picked up on the next cycle with the
            // inputs present then.
            if (hit) begin
                if (match) begin
                    pass_count_next = pass_count_reg + (IDX_W + 1)'(1);
                end else begin
                    fail_mask_next = fail_mask_reg | cur_onehot;
                end
                if (!last_test) begin
                    cur_test_next = cur_test_reg + IDX_W'(1);
                end
            end

            // Watchdog expiry without a final hit. A checkpoint hit on this
            // same edge has already been scored above. Everything after it,
            // and the current one if it was not hit, is marked failed.
            if (wdog_expire && !(hit && last_test)) begin
                fail_mask_next = fail_mask_next | tail_mask;
                if (!hit) begin
                    fail_mask_next = fail_mask_next | cur_onehot;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            pass_count_reg <= '0;
            fail_mask_reg  <= '0;
            cur_test_reg   <= '0;
            wdog_reg       <= '0;
        end else begin
            pass_count_reg <= pass_count_next;
            fail_mask_reg  <= fail_mask_next;
            cur_test_reg   <= cur_test_next;
            wdog_reg       <= wdog_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (state_reg == S_RUN);
        done       = (state_reg == S_DONE) || (state_reg == S_TIMEOUT);
        timeout    = (state_reg == S_TIMEOUT);
        all_passed = (state_reg == S_DONE) && (pass_count_reg == NUM_TESTS_CNT);
    end

    assign pass_count = pass_count_reg;
    assign fail_mask  = fail_mask_reg;
    assign cur_test   = cur_test_reg;

endmodule

// File: tb/tb_proc_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_proc_test_monitor
//
// Self-checking bench for proc_test_monitor. There are two instances: one with
// the default watchdog limit (255) and one with a short limit (8) for the
// same-edge race cases. Both instances share all inputs. Each task pushes the
// expected output vector to a scoreboard queue as it drives a stimulus cycle.
// After the edge it pops the entry and compares it with the DUT.
// Output vector layout: {busy, done, timeout, all_passed, pass_count[4:0],
// fail_mask[1:0], cur_test[3:0]}.
// -----------------------------------------------------------------------------
module tb_proc_test_monitor;

    localparam logic [63:0] V1 = 64'h1234_5678_9ABC_DEF0;

    logic        CLK;
    logic        resetl;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [63:0] cfg_pc;
    logic [63:0] cfg_expected;
    logic        start;
    logic [63:0] currentpc;
    logic [63:0] memtoregout;

    logic        busy, done, timeout, all_passed;
    logic [4:0]  pass_count;
    logic [1:0]  fail_mask;
    logic [3:0]  cur_test;

    logic        busy_8, done_8, timeout_8, all_passed_8;
    logic [4:0]  pass_count_8;
    logic [1:0]  fail_mask_8;
    logic [3:0]  cur_test_8;

    int checks   = 0;
    int failures = 0;

    logic [14:0] sb_exp  [$];
    string       sb_name [$];

    proc_test_monitor #(
        .NUM_TESTS(2), .IDX_W(4), .DATA_W(64), .WDOG_W(16), .WDOG_LIMIT(255)
    ) dut (
        .CLK(CLK), .resetl(resetl), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_pc(cfg_pc), .cfg_expected(cfg_expected), .start(start),
        .currentpc(currentpc), .memtoregout(memtoregout),
        .busy(busy), .done(done), .timeout(timeout), .all_passed(all_passed),
        .pass_count(pass_count), .fail_mask(fail_mask), .cur_test(cur_test)
    );

    proc_test_monitor #(
        .NUM_TESTS(2), .IDX_W(4), .DATA_W(64), .WDOG_W(16), .WDOG_LIMIT(8)
    ) dut8 (
        .CLK(CLK), .resetl(resetl), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_pc(cfg_pc), .cfg_expected(cfg_expected), .start(start),
        .currentpc(currentpc), .memtoregout(memtoregout),
        .busy(busy_8), .done(done_8), .timeout(timeout_8), .all_passed(all_passed_8),
        .pass_count(pass_count_8), .fail_mask(fail_mask_8), .cur_test(cur_test_8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [14:0] ev(input int b, input int d, input int t, input int a,
                                       input int p, input int m, input int c);
        return {b[0], d[0], t[0], a[0], p[4:0], m[1:0], c[3:0]};
    endfunction

    function automatic logic [14:0] obs();
        return {busy, done, timeout, all_passed, pass_count, fail_mask, cur_test};
    endfunction

    function automatic logic [14:0] obs8();
        return {busy_8, done_8, timeout_8, all_passed_8, pass_count_8, fail_mask_8, cur_test_8};
    endfunction

    // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic [63:0] pc, input logic [63:0] data, input logic st);
        currentpc   = pc;
        memtoregout = data;
        start       = st;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic load(input logic [3:0] idx, input logic [63:0] pc, input logic [63:0] ex);
        cfg_we       = 1'b1;
        cfg_idx      = idx;
        cfg_pc       = pc;
        cfg_expected = ex;
        @(posedge CLK);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic apply_reset();
        resetl = 1'b0;
        drive(64'd0, 64'd0, 1'b0);
        drive(64'd0, 64'd0, 1'b0);
        resetl = 1'b1;
    endtask

    // Reset clears everything; start asserted during reset must be ignored.
    task automatic test_reset();
        logic [14:0] e, got;
        string nm;
        for (int k = 0; k < 3; k++) begin
            resetl = (k == 2);
            sb_exp.push_back(ev(0, 0, 0, 0, 0, 0, 0));
            sb_name.push_back($sformatf("reset_k%0d", k));
            drive(64'h40, 64'hF, (k == 1));
            got = obs(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s observed=%h expected=%h", nm, got, e);
            end else $display("txn %s value=%h", nm, got);
        end
        resetl = 1'b1;
    endtask

    // Full program walk: PC 0..0x5C step 4, correct values at both checkpoints.
    task automatic test_program_pass();
        logic [63:0] pc, d;
        logic [14:0] e, got;
        string nm;
        apply_reset();
        load(4'd0, 64'h30, 64'hF);
        load(4'd1, 64'h5C, V1);
        load(4'd2, 64'hFFFF_FFFF, 64'd0);   // out of range, must not alias entry 0
        load(4'd15, 64'hFFFF_FFFF, 64'd0);
        for (int k = 0; k <= 26; k++) begin
            pc = (k == 0) ? 64'd0 : ((k <= 24) ? 64'((k - 1) * 4) : 64'h100);
            d  = (pc < 64'h30) ? 64'd0 : ((pc == 64'h30) ? 64'hF : V1);
            if (k == 0 || pc < 64'h30) e = ev(1, 0, 0, 0, 0, 0, 0);
            else if (pc < 64'h5C)      e = ev(1, 0, 0, 0, 1, 0, 1);
            else                       e = ev(0, 1, 0, 1, 2, 0, 1);
            sb_exp.push_back(e);
            sb_name.push_back($sformatf("pass_k%0d", k));
            drive(pc, d, (k == 0));
            got = obs(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s observed=%h expected=%h", nm, got, e);
            end else $display("txn %s pc=%h value=%h", nm, pc, got);
        end
    endtask

    // Wrong value at checkpoint 0; restart from DONE with the table retained.
    task automatic test_mismatch();
        logic [63:0] pc, d;
        logic [14:0] e, got;
        string nm;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin pc = 64'h0;  d = 64'h0; e = ev(1, 0, 0, 0, 0, 0, 0); end
                1: begin pc = 64'h30; d = 64'hE; e = ev(1, 0, 0, 0, 0, 1, 1); end
                2: begin pc = 64'h40; d = V1;    e = ev(1, 0, 0, 0, 0, 1, 1); end
                default: begin pc = 64'h5C; d = V1; e = ev(0, 1, 0, 0, 1, 1, 1); end
            endcase
            sb_exp.push_back(e);
            sb_name.push_back($sformatf("mismatch_k%0d", k));
            drive(pc, d, (k == 0));
            got = obs(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s observed=%h expected=%h", nm, got, e);
            end else $display("txn %s pc=%h value=%h", nm, pc, got);
        end
    endtask

    // PC parked below every threshold: the watchdog must fire 255 cycles after start.
    task automatic test_watchdog();
        int cyc;
        logic [14:0] e, got;
        string nm;
        drive(64'h10, 64'd0, 1'b1);
        cyc = 0;
        while (!done && cyc < 300) begin
            drive(64'h10, 64'd0, 1'b0);
            cyc++;
        end
        checks++;
        if (cyc !== 255) begin
            failures++;
            $display("FAIL wdog_cycles observed=%0d expected=255", cyc);
        end else $display("txn wdog_cycles value=%0d", cyc);
        sb_exp.push_back(ev(0, 1, 1, 0, 0, 3, 0));
        sb_name.push_back("wdog_state");
        got = obs(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", nm, got, e);
        end else $display("txn %s value=%h", nm, got);
    endtask

    // WDOG_LIMIT=8 instance. Scenario 0: final hit on edge 8 -> DONE.
    // Scenario 1: non-final hit on edge 8 -> scored, then TIMEOUT.
    task automatic test_race();
        logic [63:0] pc, d;
        logic [14:0] e, got;
        string nm;
        for (int s = 0; s < 2; s++) begin
            drive(64'h0, 64'd0, 1'b1);
            for (int k = 1; k <= 8; k++) begin
                if (s == 0) begin
                    pc = (k == 1) ? 64'h30 : ((k == 8) ? 64'h5C : 64'h40);
                    d  = (k == 1) ? 64'hF : ((k == 8) ? V1 : 64'd0);
                    e  = (k == 8) ? ev(0, 1, 0, 1, 2, 0, 1) : ev(1, 0, 0, 0, 1, 0, 1);
                end else begin
                    pc = (k == 8) ? 64'h30 : 64'h10;
                    d  = (k == 8) ? 64'hF : 64'd0;
                    e  = (k == 8) ? ev(0, 1, 1, 0, 1, 2, 1) : ev(1, 0, 0, 0, 0, 0, 0);
                end
                sb_exp.push_back(e);
                sb_name.push_back($sformatf("race_s%0d_k%0d", s, k));
                drive(pc, d, 1'b0);
                got = obs8(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s observed=%h expected=%h", nm, got, e);
                end else $display("txn %s pc=%h value=%h", nm, pc, got);
            end
        end
    endtask

    // Equal thresholds: evaluated on consecutive cycles, each with its own inputs.
    task automatic test_back_to_back();
        logic [63:0] d;
        logic [14:0] e, got;
        string nm;
        apply_reset();
        load(4'd0, 64'h20, 64'hAA);
        load(4'd1, 64'h20, 64'hAA);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin d = 64'h0;  e = ev(1, 0, 0, 0, 0, 0, 0); end
                1: begin d = 64'hAA; e = ev(1, 0, 0, 0, 1, 0, 1); end
                2: begin d = 64'hBB; e = ev(0, 1, 0, 0, 1, 2, 1); end
                default: begin d = 64'hAA; e = ev(0, 1, 0, 0, 1, 2, 1); end
            endcase
            sb_exp.push_back(e);
            sb_name.push_back($sformatf("b2b_k%0d", k));
            drive((k == 0) ? 64'h0 : 64'h24, d, (k == 0));
            got = obs(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s observed=%h expected=%h", nm, got, e);
            end else $display("txn %s value=%h", nm, got);
        end
    endtask

    // cfg_we and start during RUN have no effect.
    task automatic test_ignored();
        logic [63:0] pc, d;
        logic [14:0] e, got;
        string nm;
        logic st;
        apply_reset();
        load(4'd0, 64'h30, 64'hF);
        load(4'd1, 64'h5C, V1);
        for (int k = 0; k < 5; k++) begin
            st = (k == 0) || (k == 3);
            case (k)
                0: begin pc = 64'h0;  d = 64'h0; e = ev(1, 0, 0, 0, 0, 0, 0); end
                1: begin pc = 64'h8;  d = 64'h0; e = ev(1, 0, 0, 0, 0, 0, 0); end
                2: begin pc = 64'h30; d = 64'hF; e = ev(1, 0, 0, 0, 1, 0, 1); end
                3: begin pc = 64'h40; d = 64'h0; e = ev(1, 0, 0, 0, 1, 0, 1); end
                default: begin pc = 64'h5C; d = V1; e = ev(0, 1, 0, 1, 2, 0, 1); end
            endcase
            if (k == 1) begin
                cfg_we = 1'b1; cfg_idx = 4'd0; cfg_pc = 64'h4; cfg_expected = 64'hE;
            end
            sb_exp.push_back(e);
            sb_name.push_back($sformatf("ignored_k%0d", k));
            drive(pc, d, st);
            cfg_we = 1'b0;
            got = obs(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s observed=%h expected=%h", nm, got, e);
            end else $display("txn %s pc=%h value=%h", nm, pc, got);
        end
    endtask

    // Reset mid-run clears outputs and the table; a restart sees thresholds of 0.
    task automatic test_reset_mid_run();
        logic [63:0] pc, d;
        logic [14:0] e, got;
        string nm;
        logic st;
        for (int k = 0; k < 6; k++) begin
            st = (k == 0) || (k == 3);
            resetl = (k != 2);
            case (k)
                0: begin pc = 64'h0;  d = 64'h0; e = ev(1, 0, 0, 0, 0, 0, 0); end
                1: begin pc = 64'h30; d = 64'hF; e = ev(1, 0, 0, 0, 1, 0, 1); end
                2: begin pc = 64'h40; d = 64'h0; e = ev(0, 0, 0, 0, 0, 0, 0); end
                3: begin pc = 64'h8;  d = 64'h5; e = ev(1, 0, 0, 0, 0, 0, 0); end
                4: begin pc = 64'h8;  d = 64'h5; e = ev(1, 0, 0, 0, 0, 1, 1); end
                default: begin pc = 64'h8; d = 64'h0; e = ev(0, 1, 0, 0, 1, 1, 1); end
            endcase
            sb_exp.push_back(e);
            sb_name.push_back($sformatf("midreset_k%0d", k));
            drive(pc, d, st);
            got = obs(); e = sb_exp.pop_front(); nm = sb_name.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s observed=%h expected=%h", nm, got, e);
            end else $display("txn %s pc=%h value=%h", nm, pc, got);
        end
        resetl = 1'b1;
    endtask

    initial begin
        resetl       = 1'b0;
        cfg_we       = 1'b0;
        cfg_idx      = 4'd0;
        cfg_pc       = 64'd0;
        cfg_expected = 64'd0;
        start        = 1'b0;
        currentpc    = 64'd0;
        memtoregout  = 64'd0;

        test_reset();
        test_program_pass();
        test_mismatch();
        test_watchdog();
        test_race();
        test_back_to_back();
        test_ignored();
        test_reset_mid_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/proc_test_monitor.md
Name: proc_test_monitor

Overview:
- Synthesizable, parametrised checker for the single-cycle processor's `currentpc` and `MemtoRegOut`.
- Holds a table of NUM_TESTS checkpoints, each a PC threshold plus an expected result.
- Evaluates checkpoints in order as the PC advances and counts passes.
- Flags completion, and enforces a cycle watchdog that kills the run on a runaway program.
- Sits beside `singlecycle` for on-chip/FPGA self-test, replacing simulation-only pass/fail tasks.

Parameters:
- NUM_TESTS, 2, number of checkpoints; 1..2^IDX_W.
- IDX_W, 4, width of checkpoint index.
- DATA_W, 64, width of PC and result buses.
- WDOG_W, 16, width of watchdog counter.
- WDOG_LIMIT, 255, run-cycle count at which the watchdog expires.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- resetl  in  1  synchronous active-low reset.
- cfg_we  in  1  checkpoint table write strobe; honoured only in IDLE.
- cfg_idx  in  IDX_W  table entry to write; writes with cfg_idx >= NUM_TESTS ignored.
- cfg_pc  in  DATA_W  PC threshold for the entry.
- cfg_expected  in  DATA_W  expected MemtoRegOut for the entry.
- start  in  1  begin run; honoured in IDLE, DONE, TIMEOUT.
- currentpc  in  DATA_W  processor PC.
- memtoregout  in  DATA_W  processor writeback value.
- busy  out  1  high in RUN.
- done  out  1  high in DONE or TIMEOUT.
- timeout  out  1  high in TIMEOUT.
- all_passed  out  1  high in DONE when pass_count == NUM_TESTS.
- pass_count  out  IDX_W+1  checkpoints passed this run.
- fail_mask  out  NUM_TESTS  bit i set if checkpoint i failed or was never reached.
- cur_test  out  IDX_W  index of the checkpoint currently awaited.

Behaviour:
- Reset (resetl low at a rising edge):
  - state=IDLE; busy, done, timeout, all_passed = 0; pass_count=0; fail_mask=0; cur_test=0; watchdog=0.
  - All table entries cleared to pc=0, expected=0.
  - Reset mid-run aborts the run with no partial results kept.
- States:
  - IDLE: cfg writes take effect next cycle; start -> RUN.
  - RUN: active checking (see below).
  - DONE, TIMEOUT: hold all results; start -> RUN.
- Run start (any start into RUN): same edge clears pass_count, fail_mask, cur_test, watchdog. Table is retained.
- In RUN, every cycle:
  - watchdog increments, saturating at 2^WDOG_W-1.
  - Checkpoint hit when currentpc >= table[cur_test].pc (unsigned).
  - On a hit: if memtoregout == table[cur_test].expected then pass_count+1, else set fail_mask[cur_test]; then cur_test+1.
  - Compare uses the same-cycle inputs; results are registered, visible 1 cycle after the hit edge.
  - At most one checkpoint is evaluated per cycle. If the next threshold is also satisfied, it is evaluated on the following cycle with the then-current inputs.
  - Hit on checkpoint NUM_TESTS-1 -> DONE; cur_test stays NUM_TESTS-1.
  - Watchdog: when watchdog == WDOG_LIMIT-1 at an edge with no final hit -> TIMEOUT. Every unevaluated checkpoint (cur_test..NUM_TESTS-1) gets its fail_mask bit set.
  - Final-checkpoint hit and watchdog expiry on the same edge: the checkpoint is evaluated and DONE wins.
  - A non-final hit and watchdog expiry on the same edge: that hit is evaluated, then the remaining checkpoints are marked failed and the state goes to TIMEOUT.
- Ignored inputs:
  - start in RUN.
  - cfg_we outside IDLE.
- Output timing: all outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Width rules:
  - pass_count never exceeds NUM_TESTS.
  - Thresholds are not required to be monotonic. A lower later threshold hits immediately.

Test Plan:
- Program 1 pass: reset; load entry0 pc=0x30 expected=0xF and entry1 pc=0x5C expected=0x123456789ABCDEF0; start; drive PC 0,4,…,0x30 with memtoregout=0xF at 0x30, then up to 0x5C with the value 0x123456789ABCDEF0 -> DONE, all_passed=1, pass_count=2, fail_mask=0.
- Mismatch: same table, drive 0xE at PC 0x30 -> DONE, pass_count=1, fail_mask=2'b01, all_passed=0.
- Watchdog: WDOG_LIMIT=255; after start hold PC at 0x10 -> TIMEOUT exactly 255 cycles after start, fail_mask=2'b11, pass_count=0, done=1.
- Same-edge race: WDOG_LIMIT=8; final hit with a correct value on cycle 8 -> DONE, not TIMEOUT.
- Back-to-back thresholds: entry0 pc=0x20, entry1 pc=0x20; jump PC to 0x24 -> two evaluations on consecutive cycles, cur_test 0→1, then DONE.
- Control/reset edge cases:
  - cfg_we during RUN does not alter the table.
  - start during RUN is ignored.
  - resetl low mid-run -> all outputs 0 next cycle and the table is cleared; restart with no reload fails at the threshold 0 hit unless memtoregout=0.
